// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - request/control bundle between EX/CLINT/bus and pipe_ctrl
//
// master : requester side (EX, CLINT, bus); drives the requests and observes the controls
// slave  : pipe_ctrl side; receives the requests and drives the controls
// Requests : ex_jump_req_i/ex_jump_addr_i, irq_req_i/irq_addr_i/irq_en_i,
//            ex_hold_req_i, bus_hold_req_i
// Controls : jump_flag_o/jump_addr_o, hold_o, flush_o, irq_ack_o, busy_o,
//            redirect_cnt_o
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              ex_jump_req_i;
    logic [ADDR_W-1:0] ex_jump_addr_i;
    logic              irq_req_i;
    logic [ADDR_W-1:0] irq_addr_i;
    logic              irq_en_i;
    logic              ex_hold_req_i;
    logic              bus_hold_req_i;

    logic              jump_flag_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              hold_o;
    logic              flush_o;
    logic              irq_ack_o;
    logic              busy_o;
    logic [CNT_W-1:0]  redirect_cnt_o;

    modport master (
        output ex_jump_req_i, ex_jump_addr_i, irq_req_i, irq_addr_i, irq_en_i,
               ex_hold_req_i, bus_hold_req_i,
        input  jump_flag_o, jump_addr_o, hold_o, flush_o, irq_ack_o, busy_o,
               redirect_cnt_o
    );

    modport slave (
        input  ex_jump_req_i, ex_jump_addr_i, irq_req_i, irq_addr_i, irq_en_i,
               ex_hold_req_i, bus_hold_req_i,
        output jump_flag_o, jump_addr_o, hold_o, flush_o, irq_ack_o, busy_o,
               redirect_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RV32 pipeline redirect/stall arbitration and flush sequencer
//
// Ports:
//   clk  : core clock, all state updates on rising edge
//   rst  : synchronous active-high reset
//   bus  : pipe_ctrl_if.slave (requests in, pc_reg/if_id/id_ex controls out)
// Parameters:
//   ADDR_W       : PC / redirect target width
//   FLUSH_CYCLES : flush length after a redirect (1..15)
//   CNT_W        : redirect counter width
module pipe_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t             state_q;
    state_t             state_d;
    logic [3:0]         flush_cnt_q;
    logic [3:0]         flush_cnt_d;
    logic               flush_q;
    logic               irq_ack_q;
    logic [CNT_W-1:0]   redirect_cnt_q;

    logic               irq_take;
    logic               jump_take;
    logic               redirect;

    logic               jump_flag;
    logic [ADDR_W-1:0]  jump_addr;
    logic               hold;

    // An interrupt is only taken with no hold pending, so a multi-cycle EX
    // op is never cut mid-flight. EX jumps seen during FLUSH come from
    // squashed instructions, hence the RUN qualifier on both.
    assign irq_take  = (state_q == RUN) && bus.irq_req_i && bus.irq_en_i &&
                       !bus.ex_hold_req_i && !bus.bus_hold_req_i;
    assign jump_take = (state_q == RUN) && !irq_take && bus.ex_jump_req_i;
    assign redirect  = irq_take || jump_take;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            flush_cnt_q    <= 4'd0;
            flush_q        <= 1'b0;
            irq_ack_q      <= 1'b0;
            redirect_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            flush_q     <= (state_d == FLUSH);
            irq_ack_q   <= irq_take;
            if (redirect && (redirect_cnt_q != CNT_MAX)) begin
                redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end
            end
            FLUSH: begin
                // A stalled bus freezes the pipeline, so the flush is
                // stretched rather than consumed while it is held.
                if (!bus.bus_hold_req_i) begin
                    if (flush_cnt_q <= 4'd1) begin
                        state_d     = RUN;
                        flush_cnt_d = 4'd0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = 4'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        jump_flag = 1'b0;
        jump_addr = '0;
        hold      = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (irq_take) begin
                        jump_flag = 1'b1;
                        jump_addr = bus.irq_addr_i;
                    end else if (jump_take) begin
                        // A redirect overrides any hold request in the same cycle.
                        jump_flag = 1'b1;
                        jump_addr = bus.ex_jump_addr_i;
                    end else begin
                        hold = bus.ex_hold_req_i || bus.bus_hold_req_i;
                    end
                end
                FLUSH: begin
                    hold = bus.bus_hold_req_i;
                end
                default: begin
                    hold = 1'b0;
                end
            endcase
        end
    end

    assign bus.jump_flag_o    = jump_flag;
    assign bus.jump_addr_o    = jump_addr;
    assign bus.hold_o         = hold;
    assign bus.flush_o        = flush_q;
    assign bus.irq_ack_o      = irq_ack_q;
    assign bus.busy_o         = (state_q != RUN);
    assign bus.redirect_cnt_o = redirect_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int ADDR_W  = 32;
    localparam int FC      = 2;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_if ();

    pipe_ctrl #(
        .ADDR_W(ADDR_W),
        .FLUSH_CYCLES(FC),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // behavioural model: flush cycles still owed, pending ack, redirect tally
    int m_rem = 0;
    bit m_ack = 1'b0;
    int m_cnt = 0;

    // values sampled in the last cycle
    logic              s_flag, s_hold, s_flush, s_ack, s_busy;
    logic [ADDR_W-1:0] s_addr;
    logic [CNT_W-1:0]  s_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Called at posedge+1: drive inputs, sample before next edge, compare
    // against the model, advance the model, return at next posedge+1.
    task automatic run_cycle(input logic r, input logic jr, input logic [31:0] ja,
                             input logic irq, input logic ien, input logic [31:0] ia,
                             input logic exh, input logic bh);
        bit        e_flag, e_hold, e_flush, e_ack;
        logic [31:0] e_addr;
        int        e_cnt;
        int        n_rem;
        bit        n_ack;
        int        n_cnt;

        rst                   = r;
        bus_if.ex_jump_req_i  = jr;
        bus_if.ex_jump_addr_i = ja;
        bus_if.irq_req_i      = irq;
        bus_if.irq_en_i       = ien;
        bus_if.irq_addr_i     = ia;
        bus_if.ex_hold_req_i  = exh;
        bus_if.bus_hold_req_i = bh;
        #3;
        s_flag  = bus_if.jump_flag_o;
        s_addr  = bus_if.jump_addr_o;
        s_hold  = bus_if.hold_o;
        s_flush = bus_if.flush_o;
        s_ack   = bus_if.irq_ack_o;
        s_busy  = bus_if.busy_o;
        s_cnt   = bus_if.redirect_cnt_o;

        e_flush = (m_rem > 0);
        e_ack   = m_ack;
        e_cnt   = m_cnt;
        e_flag  = 1'b0;
        e_addr  = 32'h0;
        e_hold  = 1'b0;
        n_rem   = m_rem;
        n_ack   = 1'b0;
        n_cnt   = m_cnt;
        if (r) begin
            n_rem = 0;
            n_cnt = 0;
        end else if (m_rem == 0) begin
            if (irq && ien && !exh && !bh) begin
                e_flag = 1'b1;
                e_addr = ia;
                n_rem  = FC;
                n_ack  = 1'b1;
                n_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
            end else if (jr) begin
                e_flag = 1'b1;
                e_addr = ja;
                n_rem  = FC;
                n_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
            end else begin
                e_hold = exh || bh;
            end
        end else begin
            e_hold = bh;
            n_rem  = bh ? m_rem : m_rem - 1;
        end

        chk("model jump_flag", 32'(s_flag), 32'(e_flag));
        chk("model jump_addr", s_addr, e_addr);
        chk("model hold", 32'(s_hold), 32'(e_hold));
        chk("model flush", 32'(s_flush), 32'(e_flush));
        chk("model busy", 32'(s_busy), 32'(e_flush));
        chk("model irq_ack", 32'(s_ack), 32'(e_ack));
        chk("model redirect_cnt", 32'(s_cnt), 32'(e_cnt));

        m_rem = n_rem;
        m_ack = n_ack;
        m_cnt = n_cnt;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, jr;
        logic [31:0] ja;
        logic        irq, ien;
        logic [31:0] ia;
        logic        exh, bh;
        logic        e_flag;
        logic [31:0] e_addr;
        logic        e_hold, e_flush, e_ack;
        int          e_cnt;
    } vec_t;

    vec_t rows[$];

    function automatic vec_t mk(logic r, logic jr, logic [31:0] ja, logic irq, logic ien,
                                logic [31:0] ia, logic exh, logic bh, logic ef,
                                logic [31:0] ea, logic eh, logic efl, logic eak, int ec);
        vec_t v;
        v.rst = r;  v.jr = jr;  v.ja = ja;  v.irq = irq; v.ien = ien; v.ia = ia;
        v.exh = exh; v.bh = bh; v.e_flag = ef; v.e_addr = ea; v.e_hold = eh;
        v.e_flush = efl; v.e_ack = eak; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        // reset: two cycles with everything requesting, then irq first cycle out
        rows.push_back(mk(1,1,32'h200,1,1,32'h80,1,1, 0,32'h0,0,0,0,0));
        rows.push_back(mk(1,1,32'h200,1,1,32'h80,1,1, 0,32'h0,0,0,0,0));
        rows.push_back(mk(0,0,32'h0,1,1,32'h80,0,0,   1,32'h80,0,0,0,0));
        rows.push_back(mk(0,0,32'h0,1,1,32'h80,0,0,   0,32'h0,0,1,1,1));
        rows.push_back(mk(0,0,32'h0,0,1,32'h80,0,0,   0,32'h0,0,1,0,1));
        rows.push_back(mk(0,0,32'h0,0,1,32'h80,0,0,   0,32'h0,0,0,0,1));
        // plain jump
        rows.push_back(mk(0,1,32'h100,0,0,32'h0,0,0,  1,32'h100,0,0,0,1));
        rows.push_back(mk(0,0,32'h0,0,0,32'h0,0,0,    0,32'h0,0,1,0,2));
        rows.push_back(mk(0,0,32'h0,0,0,32'h0,0,0,    0,32'h0,0,1,0,2));
        rows.push_back(mk(0,0,32'h0,0,0,32'h0,0,0,    0,32'h0,0,0,0,2));
        // irq beats jump; jumps ignored while flushing
        rows.push_back(mk(0,1,32'h200,1,1,32'h80,0,0, 1,32'h80,0,0,0,2));
        rows.push_back(mk(0,1,32'h200,0,1,32'h80,0,0, 0,32'h0,0,1,1,3));
        rows.push_back(mk(0,1,32'h200,0,1,32'h80,0,0, 0,32'h0,0,1,0,3));
        rows.push_back(mk(0,0,32'h0,0,1,32'h80,0,0,   0,32'h0,0,0,0,3));
        // ex hold blocks irq for 5 cycles
        for (int i = 0; i < 5; i++)
            rows.push_back(mk(0,0,32'h0,1,1,32'h80,1,0, 0,32'h0,1,0,0,3));
        rows.push_back(mk(0,0,32'h0,1,1,32'h80,0,0,   1,32'h80,0,0,0,3));
        rows.push_back(mk(0,0,32'h0,0,1,32'h80,0,0,   0,32'h0,0,1,1,4));
        rows.push_back(mk(0,0,32'h0,0,1,32'h80,0,0,   0,32'h0,0,1,0,4));
        rows.push_back(mk(0,0,32'h0,0,1,32'h80,0,0,   0,32'h0,0,0,0,4));
        // bus hold stretches the flush
        rows.push_back(mk(0,1,32'h300,0,0,32'h0,0,0,  1,32'h300,0,0,0,4));
        for (int i = 0; i < 3; i++)
            rows.push_back(mk(0,0,32'h0,0,0,32'h0,0,1, 0,32'h0,1,1,0,5));
        rows.push_back(mk(0,0,32'h0,0,0,32'h0,0,0,    0,32'h0,0,1,0,5));
        rows.push_back(mk(0,0,32'h0,0,0,32'h0,0,0,    0,32'h0,0,1,0,5));
        rows.push_back(mk(0,0,32'h0,0,0,32'h0,0,0,    0,32'h0,0,0,0,5));
        // jump overrides holds; ex hold not reflected during flush
        rows.push_back(mk(0,1,32'h400,0,0,32'h0,1,1,  1,32'h400,0,0,0,5));
        rows.push_back(mk(0,0,32'h0,0,0,32'h0,1,0,    0,32'h0,0,1,0,6));
        rows.push_back(mk(0,0,32'h0,0,0,32'h0,0,0,    0,32'h0,0,1,0,6));
        rows.push_back(mk(0,0,32'h0,0,0,32'h0,0,0,    0,32'h0,0,0,0,6));
        // irq disabled: no redirect
        rows.push_back(mk(0,0,32'h0,1,0,32'h80,0,0,   0,32'h0,0,0,0,6));

        bus_if.ex_jump_req_i  = 1'b0;
        bus_if.ex_jump_addr_i = '0;
        bus_if.irq_req_i      = 1'b0;
        bus_if.irq_addr_i     = '0;
        bus_if.irq_en_i       = 1'b0;
        bus_if.ex_hold_req_i  = 1'b0;
        bus_if.bus_hold_req_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (rows[i]) begin
            run_cycle(rows[i].rst, rows[i].jr, rows[i].ja, rows[i].irq, rows[i].ien,
                      rows[i].ia, rows[i].exh, rows[i].bh);
            chk($sformatf("row%0d jump_flag", i), 32'(s_flag), 32'(rows[i].e_flag));
            chk($sformatf("row%0d jump_addr", i), s_addr, rows[i].e_addr);
            chk($sformatf("row%0d hold", i), 32'(s_hold), 32'(rows[i].e_hold));
            chk($sformatf("row%0d flush", i), 32'(s_flush), 32'(rows[i].e_flush));
            chk($sformatf("row%0d busy", i), 32'(s_busy), 32'(rows[i].e_flush));
            chk($sformatf("row%0d irq_ack", i), 32'(s_ack), 32'(rows[i].e_ack));
            chk($sformatf("row%0d redirect_cnt", i), 32'(s_cnt), 32'(rows[i].e_cnt));
        end

        // saturation: clear, preload to all-ones, then one more jump
        run_cycle(1,0,0,0,0,0,0,0);
        for (int i = 0; i < CNT_MAX; i++) begin
            run_cycle(0,1,32'h1000 + 32'(i),0,0,0,0,0);
            run_cycle(0,0,0,0,0,0,0,0);
            run_cycle(0,0,0,0,0,0,0,0);
        end
        run_cycle(0,1,32'h500,0,0,0,0,0);
        chk("sat jump_flag", 32'(s_flag), 32'd1);
        chk("sat cnt before", 32'(s_cnt), 32'(CNT_MAX));
        // reset during the flush that follows
        run_cycle(1,0,0,0,0,0,0,0);
        chk("sat cnt no wrap", 32'(s_cnt), 32'(CNT_MAX));
        chk("rst mid flush, flush still up", 32'(s_flush), 32'd1);
        run_cycle(0,0,0,0,0,0,0,0);
        chk("after rst flush", 32'(s_flush), 32'd0);
        chk("after rst busy", 32'(s_busy), 32'd0);
        chk("after rst cnt", 32'(s_cnt), 32'd0);

        // reset right after an irq drops the pending ack
        run_cycle(0,0,0,1,1,32'h80,0,0);
        chk("irq before rst", 32'(s_flag), 32'd1);
        run_cycle(1,0,0,0,1,32'h80,0,0);
        run_cycle(0,0,0,0,1,32'h80,0,0);
        chk("ack dropped by rst", 32'(s_ack), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            run_cycle(($urandom_range(0, 59) == 0),
                      ($urandom_range(0, 3) == 0), $urandom,
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1), $urandom,
                      ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control block for the RV32 core. It arbitrates redirect requests (interrupt entry from the CLINT, branch/jump from EX) and stall requests (EX multi-cycle ops, bus wait). It drives the PC register's jump flag/address and a hold flag, and sequences a fixed-length flush of the IF/ID and ID/EX stages after every redirect. It sits between EX/CLINT/bus and pc_reg, if_id, id_ex.

## Interface
- ADDR_W, 32, width of PC/jump addresses
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect (legal 1..15)
- CNT_W, 16, width of redirect counter
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- ex_jump_req_i  in  1  EX requests redirect (branch taken/jal/jalr), level, valid one cycle
- ex_jump_addr_i  in  ADDR_W  EX redirect target
- irq_req_i  in  1  CLINT interrupt pending, level, held until acked
- irq_addr_i  in  ADDR_W  trap vector target
- irq_en_i  in  1  global interrupt enable (mstatus.MIE)
- ex_hold_req_i  in  1  EX multi-cycle op busy
- bus_hold_req_i  in  1  memory bus not ready
- jump_flag_o  out  1  to pc_reg: load jump_addr_o at next edge
- jump_addr_o  out  ADDR_W  to pc_reg: redirect target; 0 when jump_flag_o=0
- hold_o  out  1  to pc_reg/if_id/id_ex: freeze this cycle
- flush_o  out  1  to if_id/id_ex: replace contents with NOP at next edge
- irq_ack_o  out  1  to CLINT: one-cycle pulse, interrupt taken
- busy_o  out  1  state != RUN
- redirect_cnt_o  out  CNT_W  saturating count of accepted redirects

## Operation
- States: RUN, FLUSH. Down-counter flush_cnt (4 bits). Registered: state, flush_cnt, irq_ack_o, flush_o, redirect_cnt_o.
- Combinational outputs (jump_flag_o, jump_addr_o, hold_o) forced 0 while rst=1.
- RUN, decision each cycle, priority high->low:
  - irq_take = irq_req_i & irq_en_i & ~ex_hold_req_i & ~bus_hold_req_i: jump_flag_o=1, jump_addr_o=irq_addr_i, hold_o=0; next state FLUSH, flush_cnt<=FLUSH_CYCLES; irq_ack_o=1 next cycle.
  - else ex_jump_req_i: jump_flag_o=1, jump_addr_o=ex_jump_addr_i, hold_o=0 (jump overrides any hold in the same cycle); next FLUSH, flush_cnt<=FLUSH_CYCLES.
  - else hold_o = ex_hold_req_i | bus_hold_req_i; stay RUN.
- FLUSH: flush_o=1; jump_flag_o=0; ex_jump_req_i ignored (from squashed instructions); irq_req_i deferred, not lost (level input); hold_o = bus_hold_req_i; flush_cnt decrements only when bus_hold_req_i=0; at flush_cnt==1 with no bus hold -> RUN.
- redirect_cnt_o increments by 1 on each accepted redirect (irq or jump); saturates at all-ones, no wrap.
- Interrupts are blocked while any hold is active, so a multi-cycle op is never interrupted mid-flight; they are taken on the first RUN cycle with no hold.

## Timing
- Reset values: state=RUN, flush_cnt=0, flush_o=0, irq_ack_o=0, busy_o=0, redirect_cnt_o=0.
- Redirect latency: 0 cycles. Request in cycle T gives jump_flag_o=1 in T, and pc_reg loads the target at edge ending T.
- flush_o high for exactly FLUSH_CYCLES cycles, T+1..T+FLUSH_CYCLES, extended 1 cycle per cycle of bus_hold_req_i during FLUSH.
- busy_o high over the same cycles as flush_o.
- irq_ack_o high exactly in T+1 for an interrupt taken in T.
- Back-to-back: a redirect is acceptable again in the first RUN cycle after FLUSH ends, i.e. T+FLUSH_CYCLES+1 minimum.
- rst asserted mid-FLUSH: next cycle is RUN with flush_o=0, the counter cleared and any pending irq_ack_o dropped.

## Test plan
- Reset: rst=1 two cycles with all requests high -> all outputs 0; after release in RUN with irq_en_i=1, irq taken first cycle.
- Jump: ex_jump_req_i=1, addr=0x0000_0100 in T -> jump_flag_o=1, jump_addr_o=0x100 in T; flush_o=1 in T+1,T+2; busy_o=0 in T+3; redirect_cnt_o=1.
- Irq vs jump: irq_req_i=1, irq_en_i=1, ex_jump_req_i=1 (addr 0x200), irq_addr_i=0x80 same cycle -> jump_addr_o=0x80; irq_ack_o=1 next cycle only; ex jump ignored during flush.
- Hold blocks irq: ex_hold_req_i=1 for 5 cycles with irq pending -> hold_o=1 and no ack for 5 cycles; redirect to irq_addr_i in the 6th cycle.
- Bus hold in FLUSH: bus_hold_req_i=1 for 3 cycles starting T+1 -> flush_o high T+1..T+5, hold_o=1 T+1..T+3.
- Saturation and reset mid-FLUSH: preload via 65535 jumps -> counter stays 0xFFFF after the next jump; rst in T+1 -> flush_o=0 in T+2.
